// File: rtl/idea_a_if.sv
// Bundles the count-enable, terminal value and the three counter outputs of idea_a.
interface idea_a_if;
  logic       CE;
  logic [3:0] IN;
  logic [3:0] OUT;
  logic [3:0] OUT_LOGIC;
  logic [3:0] OUT_SWITCHING;

  modport master (
    output CE,
    output IN,
    input  OUT,
    input  OUT_LOGIC,
    input  OUT_SWITCHING
  );

  modport slave (
    input  CE,
    input  IN,
    output OUT,
    output OUT_LOGIC,
    output OUT_SWITCHING
  );
endinterface

// File: rtl/idea_a.sv
// 4-bit enabled modulo counter built three ways: behavioural, gate-level and mux tree.
// Define IDEAA_SWITCHING_EN to build the mux copy; otherwise OUT_SWITCHING is tied to zero.
module idea_a (
  input logic     CLK,
  input logic     RST,
  idea_a_if.slave bus
);

  // Behavioural copy: the golden reference.
  logic [3:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (bus.CE) begin
      if (out_q == bus.IN) begin
        out_d = 4'd0;
      end else begin
        out_d = out_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q <= 4'd0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.OUT = out_q;

  // Gate-level copy: only AND/OR/XOR/NOT, reset folded into the hold/advance gating.
  logic [3:0] lg_q, lg_d, lg_inc;
  logic [2:0] lg_carry;
  logic       lg_eq, lg_hold, lg_adv;

  always_comb begin
    lg_inc[0]   = ~lg_q[0];
    lg_carry[0] = lg_q[0];
    lg_inc[1]   = lg_q[1] ^ lg_carry[0];
    lg_carry[1] = lg_q[1] & lg_carry[0];
    lg_inc[2]   = lg_q[2] ^ lg_carry[1];
    lg_carry[2] = lg_q[2] & lg_carry[1];
    lg_inc[3]   = lg_q[3] ^ lg_carry[2];

    lg_eq = ~(lg_q[0] ^ bus.IN[0]) & ~(lg_q[1] ^ bus.IN[1]) &
            ~(lg_q[2] ^ bus.IN[2]) & ~(lg_q[3] ^ bus.IN[3]);

    lg_hold = ~RST & ~bus.CE;
    lg_adv  = ~RST & bus.CE & ~lg_eq;
    // Neither hold nor advance selected means clear.
    lg_d = ({4{lg_hold}} & lg_q) | ({4{lg_adv}} & lg_inc);
  end

  always_ff @(posedge CLK) begin
    lg_q <= lg_d;
  end

  assign bus.OUT_LOGIC = lg_q;

`ifdef IDEAA_SWITCHING_EN
  // Switching copy: per bit, mux tree selected by RST, then CE, then the equality term.
  logic [3:0] sw_q, sw_d, sw_inc;
  logic       sw_eq;

  always_comb begin
    sw_inc = sw_q + 4'd1;
    sw_eq  = (sw_q == bus.IN);
    sw_d   = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sw_d[i] = RST ? 1'b0 : (bus.CE ? (sw_eq ? 1'b0 : sw_inc[i]) : sw_q[i]);
    end
  end

  always_ff @(posedge CLK) begin
    sw_q <= sw_d;
  end

  assign bus.OUT_SWITCHING = sw_q;
`else
  assign bus.OUT_SWITCHING = 4'b0000;
`endif

endmodule

// File: tb/tb_idea_a.sv
// Randomised and directed bench for idea_a, checked against an arithmetic reference count.
module tb_idea_a;

`ifdef IDEAA_SWITCHING_EN
  localparam bit SwEn = 1'b1;
`else
  localparam bit SwEn = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model    = 0;

  idea_a_if bus ();

  idea_a dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference: the count as a plain integer advanced by the counting rules.
  task automatic cycle(input logic r, input logic c, input logic [3:0] v);
    RST    = r;
    bus.CE = c;
    bus.IN = v;
    @(posedge CLK);
    if (r) begin
      model = 0;
    end else if (c) begin
      model = (model == int'(v)) ? 0 : (model + 1) % 16;
    end
    #1;
  endtask

  function automatic logic [11:0] want_all();
    logic [3:0] m;
    m = 4'(model);
    return {m, m, SwEn ? m : 4'b0000};
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'(i % 2), 4'b1110);
      got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
      n_checks++;
      if (got !== 12'h000) begin
        n_fail++;
        $display("FAIL reset edge %0d: got %h required 000", i, got);
      end
    end
  endtask

  task automatic test_count_full();
    logic [11:0] got;
    cycle(1'b1, 1'b0, 4'b1110);
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b0, 1'b1, 4'b1110);
      got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
      n_checks++;
      if (got !== want_all() || model != i % 15) begin
        n_fail++;
        $display("FAIL count_full edge %0d: got %h required %h", i, got, want_all());
      end
    end
  endtask

  task automatic test_ce_pattern();
    logic [11:0] got;
    int          ce_pat[6] = '{1, 1, 0, 0, 1, 1};
    int          exp_seq[6] = '{1, 2, 2, 2, 3, 4};
    logic [3:0]  e;
    cycle(1'b1, 1'b0, 4'b1110);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'(ce_pat[i]), 4'b1110);
      e   = 4'(exp_seq[i]);
      got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
      n_checks++;
      if (got !== {e, e, SwEn ? e : 4'b0000}) begin
        n_fail++;
        $display("FAIL ce_pattern step %0d: got %h required %h", i, got,
                 {e, e, SwEn ? e : 4'b0000});
      end
    end
  endtask

  task automatic test_in_lowered();
    logic [11:0] got;
    int          exp_seq[13] = '{10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 0};
    logic [3:0]  e;
    cycle(1'b1, 1'b0, 4'b1110);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 4'b1110);
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b1, 4'b0101);
      e   = 4'(exp_seq[i]);
      got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
      n_checks++;
      if (got !== {e, e, SwEn ? e : 4'b0000} || got !== want_all()) begin
        n_fail++;
        $display("FAIL in_lowered step %0d: got %h required %h", i, got,
                 {e, e, SwEn ? e : 4'b0000});
      end
    end
  endtask

  task automatic test_in_zero_reset();
    logic [11:0] got;
    cycle(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 4'b0000);
      got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
      n_checks++;
      if (got !== 12'h000) begin
        n_fail++;
        $display("FAIL in_zero step %0d: got %h required 000", i, got);
      end
    end
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 4'b1111);
    got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
    n_checks++;
    if (got !== want_all() || model != 7) begin
      n_fail++;
      $display("FAIL mid_count before reset: got %h required %h", got, want_all());
    end
    cycle(1'b1, 1'b1, 4'b1111);
    got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_count reset: got %h required 000", got);
    end
  endtask

  task automatic test_random();
    logic [11:0] got;
    logic        r, c;
    logic [3:0]  v;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 3) != 0);
      v = 4'($urandom_range(0, 15));
      cycle(r, c, v);
      got = {bus.OUT, bus.OUT_LOGIC, bus.OUT_SWITCHING};
      n_checks++;
      if (got !== want_all()) begin
        n_fail++;
        $display("FAIL random cycle %0d rst=%b ce=%b in=%h: got %h required %h",
                 i, r, c, v, got, want_all());
      end
    end
  endtask

  initial begin
    bus.CE = 1'b0;
    bus.IN = 4'd0;
    test_reset();
    test_count_full();
    test_ce_pattern();
    test_in_lowered();
    test_in_zero_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idea_a.md
# idea_a

4-bit enabled modulo counter whose terminal value comes from the `IN` input, built three times in parallel: behavioural, gate-level and switching (mux) style. The three copies must agree on every cycle. The block is a teaching/comparison datapath: `OUT` is the golden reference, and `OUT_LOGIC` / `OUT_SWITCHING` are the structural realisations checked against it.

## Interface
- Parameters: none; width fixed at 4 bits.
- `CLK`  input  1  sole clock; all state updates on rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `CE`  input  1  count enable, active-high, sampled at `CLK` rising edge.
- `IN`  input  4  terminal count value (unsigned), sampled every cycle.
- `OUT`  output  4  behavioural counter value.
- `OUT_LOGIC`  output  4  gate-level counter value.
- `OUT_SWITCHING`  output  4  mux/switching-style counter value.

## Operation
- Three independent 4-bit state registers, one per output; no sharing of next-state logic between them.
- Next-state rule, identical for all three; priority top-down:
  - `RST`=1 -> 0.
  - `CE`=0 -> hold.
  - `CE`=1 and count == `IN` -> 0.
  - `CE`=1 otherwise -> count+1, modulo 16 (15 -> 0).
- `IN`=0: counter stays at 0 while enabled.
- If `IN` is lowered below the current count, the counter keeps incrementing, wraps 15 -> 0 naturally, then obeys the new `IN`. There is no immediate clamp.
- Implementation of each copy:
  - `OUT`: behavioural compare/increment.
  - `OUT_LOGIC`: next state from AND/OR/XOR/NOT primitives only. Uses a half-adder ripple incrementer, a 4-bit XNOR-AND equality comparator against `IN`, and a gated hold/clear.
  - `OUT_SWITCHING`: next state per bit from a tree of 2:1 multiplexers. Selects are `RST`, `CE` and the equality term; data inputs are hold, incremented, or constant 0.
- Invariant: `OUT` == `OUT_LOGIC` == `OUT_SWITCHING` on every cycle after the first reset.

## Timing
- All outputs are registered directly, with no combinational path from inputs to outputs.
- Latency: 1 cycle. A value sampled at edge k appears after edge k.
- Reset values: `OUT`=0, `OUT_LOGIC`=0, `OUT_SWITCHING`=0, one edge after `RST` is sampled high.
- Outputs are undefined before the first reset edge.
- `RST` held high: all outputs stay 0 regardless of `CE`/`IN`.
- Reset mid-count: cleared at the next edge; counting resumes from 0 on the first edge where `RST`=0 and `CE`=1.
- `CE` and wrap in the same cycle: wrap to 0 takes effect at that edge.
- `CE` toggling every cycle: the counter advances only on edges where `CE`=1.

## Configuration
- Macro: `IDEAA_SWITCHING_EN`.
- Defined: the mux-based switching copy is compiled in and drives `OUT_SWITCHING`.
- Undefined: that copy and its register are removed, and `OUT_SWITCHING` is tied to 4'b0000. `OUT` and `OUT_LOGIC` are unaffected.
- The port list is identical in both cases.

## Test plan
- `RST`=1 for 3 edges with `CE` toggling and `IN`=4'b1110 -> all three outputs 0000 after the first edge and held at 0000.
- `RST`=0, `CE`=1 continuously, `IN`=4'b1110 -> all outputs step 0,1,...,14 then 0 on the 15th enabled edge, repeating.
- `CE` pattern 1,1,0,0,1,1 (period 6, as in the course stimulus) from 0 with `IN`=1110 -> advances only on `CE`=1 edges: 1,2,2,2,3,4.
- Count at 9, change `IN` to 0101 with `CE`=1 -> outputs 10..15, then 0,...,5, then 0.
- `IN`=0000 with `CE`=1 -> outputs remain 0000; assert `RST` at count 7 -> 0000 next edge.
- Build without `IDEAA_SWITCHING_EN` and repeat scenario 2 -> `OUT`/`OUT_LOGIC` unchanged, `OUT_SWITCHING` constant 0000; with the macro, all three equal every cycle.
